pavana_ooo_slave_tagger: RTL and testbench

PAVANA_OOO_SLAVE_TAGGER -- requirements
Module: pavana_ooo_slave_tagger

---
 rtl/pavana_xbar_pkg.sv | 14 +
 rtl/pavana_tag_pool.sv | 54 +++++
 rtl/pavana_ooo_slave_tagger.sv | 95 +++++++++
 tb/tb_pavana_ooo_slave_tagger.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/pavana_xbar_pkg.sv
// Shared defaults and command encoding for the pavana crossbar slave-side blocks.
package pavana_xbar_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_TAG_WIDTH  = 2;
    localparam int unsigned DEF_NUM_TAGS   = 2 ** DEF_TAG_WIDTH;
    localparam int unsigned ADDR_WIDTH     = 32;

    typedef enum logic {
        CmdRead  = 1'b0,
        CmdWrite = 1'b1
    } xbar_cmd_e;

endpackage

// File: rtl/pavana_tag_pool.sv
// Busy bitmap of outstanding read tags with a lowest-free-index allocator.
module pavana_tag_pool
    import pavana_xbar_pkg::*;
#(
    parameter int unsigned TAG_WIDTH = DEF_TAG_WIDTH
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      alloc_en,
    input  logic                      free_en,
    input  logic [TAG_WIDTH-1:0]      free_tag,
    output logic [TAG_WIDTH-1:0]      lowest_free,
    output logic                      tag_avail,
    output logic [2**TAG_WIDTH-1:0]   busy
);

    localparam int NUM_TAGS = 2 ** TAG_WIDTH;

    logic [NUM_TAGS-1:0] busy_q, busy_d;

    // Scan downward so the last hit wins, leaving the lowest clear index.
    always_comb begin
        lowest_free = '0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                lowest_free = TAG_WIDTH'(i);
            end
        end
    end

    assign tag_avail = ~&busy_q;

    // A freed tag is busy this cycle, so it can never collide with the allocated one.
    always_comb begin
        busy_d = busy_q;
        if (free_en) begin
            busy_d[free_tag] = 1'b0;
        end
        if (alloc_en) begin
            busy_d[lowest_free] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/pavana_ooo_slave_tagger.sv
// Tags crossbar reads for an out-of-order backend and returns responses with their tag.
module pavana_ooo_slave_tagger
    import pavana_xbar_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned TAG_WIDTH  = DEF_TAG_WIDTH
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      xbar_req,
    input  logic [ADDR_WIDTH-1:0]     xbar_addr,
    input  logic                      xbar_cmd,
    input  logic [DATA_WIDTH-1:0]     xbar_wdata,
    output logic                      xbar_ack,
    output logic [TAG_WIDTH-1:0]      xbar_reqtid,
    output logic                      xbar_resp,
    output logic [TAG_WIDTH-1:0]      xbar_resptid,
    output logic [DATA_WIDTH-1:0]     xbar_rdata,
    output logic                      be_req,
    output logic [ADDR_WIDTH-1:0]     be_addr,
    output logic                      be_cmd,
    output logic [DATA_WIDTH-1:0]     be_wdata,
    output logic [TAG_WIDTH-1:0]      be_tag,
    input  logic                      be_ack,
    input  logic                      be_resp,
    input  logic [TAG_WIDTH-1:0]      be_resptag,
    input  logic [DATA_WIDTH-1:0]     be_rdata,
    output logic [2**TAG_WIDTH-1:0]   tags_busy_o,
    output logic                      tag_err_o
);

    logic                   tag_avail;
    logic [TAG_WIDTH-1:0]   free_tag;
    logic [2**TAG_WIDTH-1:0] busy;
    logic                   alloc_en;
    logic                   rsp_hit;
    logic                   rsp_miss;

    logic                   resp_q;
    logic [TAG_WIDTH-1:0]   resptid_q;
    logic [DATA_WIDTH-1:0]  rdata_q;
    logic                   tag_err_q;

    // Writes never need a tag, so they bypass the availability check.
    assign be_req   = xbar_req & ((xbar_cmd == CmdWrite) | tag_avail);
    assign be_addr  = xbar_addr;
    assign be_cmd   = xbar_cmd;
    assign be_wdata = xbar_wdata;
    assign be_tag   = free_tag;

    assign xbar_ack    = be_req & be_ack;
    assign xbar_reqtid = free_tag;

    assign alloc_en = xbar_ack & (xbar_cmd == CmdRead);
    assign rsp_hit  = be_resp & busy[be_resptag];
    assign rsp_miss = be_resp & ~busy[be_resptag];

    pavana_tag_pool #(
        .TAG_WIDTH (TAG_WIDTH)
    ) u_tag_pool (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .alloc_en    (alloc_en),
        .free_en     (rsp_hit),
        .free_tag    (be_resptag),
        .lowest_free (free_tag),
        .tag_avail   (tag_avail),
        .busy        (busy)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            resp_q    <= 1'b0;
            resptid_q <= '0;
            rdata_q   <= '0;
            tag_err_q <= 1'b0;
        end else begin
            resp_q <= rsp_hit;
            if (rsp_hit) begin
                resptid_q <= be_resptag;
                rdata_q   <= be_rdata;
            end
            if (rsp_miss) begin
                tag_err_q <= 1'b1;
            end
        end
    end

    assign xbar_resp    = resp_q;
    assign xbar_resptid = resptid_q;
    assign xbar_rdata   = rdata_q;
    assign tags_busy_o  = busy;
    assign tag_err_o    = tag_err_q;

endmodule

// File: tb/tb_pavana_ooo_slave_tagger.sv
// Scoreboard bench: expected responses queued when be_resp is driven, popped on xbar_resp.
module tb_pavana_ooo_slave_tagger;

    localparam int DW = 32;
    localparam int TW = 2;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          xbar_req;
    logic [31:0]   xbar_addr;
    logic          xbar_cmd;
    logic [DW-1:0] xbar_wdata;
    logic          xbar_ack;
    logic [TW-1:0] xbar_reqtid;
    logic          xbar_resp;
    logic [TW-1:0] xbar_resptid;
    logic [DW-1:0] xbar_rdata;
    logic          be_req;
    logic [31:0]   be_addr;
    logic          be_cmd;
    logic [DW-1:0] be_wdata;
    logic [TW-1:0] be_tag;
    logic          be_ack;
    logic          be_resp;
    logic [TW-1:0] be_resptag;
    logic [DW-1:0] be_rdata;
    logic [3:0]    tags_busy_o;
    logic          tag_err_o;

    int n_checks = 0;
    int n_errors = 0;
    logic [TW+DW-1:0] sb_q[$];
    logic             mon_en = 1'b0;

    always #5 clk_i = ~clk_i;

    pavana_ooo_slave_tagger #(
        .DATA_WIDTH (DW),
        .TAG_WIDTH  (TW)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .xbar_req     (xbar_req),
        .xbar_addr    (xbar_addr),
        .xbar_cmd     (xbar_cmd),
        .xbar_wdata   (xbar_wdata),
        .xbar_ack     (xbar_ack),
        .xbar_reqtid  (xbar_reqtid),
        .xbar_resp    (xbar_resp),
        .xbar_resptid (xbar_resptid),
        .xbar_rdata   (xbar_rdata),
        .be_req       (be_req),
        .be_addr      (be_addr),
        .be_cmd       (be_cmd),
        .be_wdata     (be_wdata),
        .be_tag       (be_tag),
        .be_ack       (be_ack),
        .be_resp      (be_resp),
        .be_resptag   (be_resptag),
        .be_rdata     (be_rdata),
        .tags_busy_o  (tags_busy_o),
        .tag_err_o    (tag_err_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Drive a backend response; push the expected crossbar response if it should be forwarded.
    task automatic drive_resp(input logic [TW-1:0] tag, input logic [DW-1:0] data,
                              input logic expect_fwd);
        be_resp    = 1'b1;
        be_resptag = tag;
        be_rdata   = data;
        if (expect_fwd) sb_q.push_back({tag, data});
    endtask

    always @(negedge clk_i) begin
        if (mon_en && xbar_resp) begin
            if (sb_q.size() == 0) begin
                check("unexpected_resp", 64'(xbar_resp), 64'(0));
            end else begin
                logic [TW+DW-1:0] e;
                e = sb_q.pop_front();
                check("resp_tid", 64'(xbar_resptid), 64'(e[TW+DW-1:DW]));
                check("resp_data", 64'(xbar_rdata), 64'(e[DW-1:0]));
            end
        end
    end

    initial begin
        rst_i = 1'b1; xbar_req = 1'b0; xbar_addr = '0; xbar_cmd = 1'b0; xbar_wdata = '0;
        be_ack = 1'b1; be_resp = 1'b0; be_resptag = '0; be_rdata = '0;
        tick(); tick();
        rst_i = 1'b0;
        #1;
        check("rst_busy", 64'(tags_busy_o), 64'h0);
        check("rst_resp", 64'(xbar_resp), 64'h0);
        check("rst_err", 64'(tag_err_o), 64'h0);
        check("rst_tid", 64'(xbar_resptid), 64'h0);
        check("rst_rdata", 64'(xbar_rdata), 64'h0);
        mon_en = 1'b1;

        // First read gets tag 0; address passes straight through.
        tick();
        xbar_req = 1'b1; xbar_cmd = 1'b0; xbar_addr = 32'h0000_0100;
        #1;
        check("rd0_ack", 64'(xbar_ack), 64'h1);
        check("rd0_tid", 64'(xbar_reqtid), 64'h0);
        check("rd0_betag", 64'(be_tag), 64'h0);
        check("rd0_addr", 64'(be_addr), 64'h100);
        tick();
        check("rd0_busy", 64'(tags_busy_o), 64'h1);

        for (int i = 1; i < 4; i++) begin
            xbar_addr = 32'h100 + 32'(i);
            #1;
            check("rdn_tid", 64'(xbar_reqtid), 64'(i));
            check("rdn_ack", 64'(xbar_ack), 64'h1);
            tick();
        end
        check("full_busy", 64'(tags_busy_o), 64'hf);

        // Fifth read is held while all tags are busy.
        #1;
        check("held_ack", 64'(xbar_ack), 64'h0);
        check("held_bereq", 64'(be_req), 64'h0);
        tick();
        check("held_ack2", 64'(xbar_ack), 64'h0);

        // Write with all tags busy goes through without allocating.
        xbar_cmd = 1'b1; xbar_wdata = 32'hDEAD_BEEF;
        #1;
        check("wr_ack", 64'(xbar_ack), 64'h1);
        check("wr_becmd", 64'(be_cmd), 64'h1);
        check("wr_wdata", 64'(be_wdata), 64'hDEADBEEF);
        tick();
        check("wr_busy", 64'(tags_busy_o), 64'hf);
        xbar_cmd = 1'b0;

        // Free tag 2 while the read waits; it may only take tag 2 next cycle.
        drive_resp(2'd2, 32'hB2, 1'b1);
        #1;
        check("free_same_ack", 64'(xbar_ack), 64'h0);
        tick();
        be_resp = 1'b0;
        #1;
        check("free_busy", 64'(tags_busy_o), 64'hb);
        check("reuse_ack", 64'(xbar_ack), 64'h1);
        check("reuse_tid", 64'(xbar_reqtid), 64'h2);
        tick();
        xbar_req = 1'b0;
        check("reuse_busy", 64'(tags_busy_o), 64'hf);

        // Out-of-order back-to-back responses.
        drive_resp(2'd2, 32'hA2, 1'b1); tick();
        drive_resp(2'd0, 32'hA0, 1'b1); tick();
        drive_resp(2'd3, 32'hA3, 1'b1); tick();
        drive_resp(2'd1, 32'hA1, 1'b1); tick();
        be_resp = 1'b0;
        tick(); tick();
        check("ooo_busy", 64'(tags_busy_o), 64'h0);
        check("hold_tid", 64'(xbar_resptid), 64'h1);
        check("hold_rdata", 64'(xbar_rdata), 64'hA1);

        // Allocate tag 0, then respond on unallocated tag 1.
        xbar_req = 1'b1; xbar_cmd = 1'b0;
        tick();
        xbar_req = 1'b0;
        check("one_busy", 64'(tags_busy_o), 64'h1);
        drive_resp(2'd1, 32'hEE, 1'b0);
        tick();
        be_resp = 1'b0;
        check("err_noresp", 64'(xbar_resp), 64'h0);
        check("err_set", 64'(tag_err_o), 64'h1);
        check("err_busy", 64'(tags_busy_o), 64'h1);
        tick(); tick();
        check("err_sticky", 64'(tag_err_o), 64'h1);

        // Same-cycle allocate of tag 1 and free of tag 0.
        xbar_req = 1'b1;
        drive_resp(2'd0, 32'h55, 1'b1);
        #1;
        check("mix_tid", 64'(xbar_reqtid), 64'h1);
        tick();
        xbar_req = 1'b0; be_resp = 1'b0;
        check("mix_busy", 64'(tags_busy_o), 64'h2);

        // Build busy = 1011, then reset with a response on freed tag 2.
        xbar_req = 1'b1;
        tick(); tick(); tick();
        xbar_req = 1'b0;
        check("pre_full", 64'(tags_busy_o), 64'hf);
        drive_resp(2'd2, 32'h77, 1'b1);
        tick();
        be_resp = 1'b0;
        check("pre_busy", 64'(tags_busy_o), 64'hb);
        rst_i = 1'b1;
        drive_resp(2'd2, 32'h99, 1'b0);
        tick();
        rst_i = 1'b0; be_resp = 1'b0;
        check("mrst_busy", 64'(tags_busy_o), 64'h0);
        check("mrst_resp", 64'(xbar_resp), 64'h0);
        check("mrst_err", 64'(tag_err_o), 64'h0);
        check("mrst_tid", 64'(xbar_resptid), 64'h0);
        tick(); tick();
        check("post_err", 64'(tag_err_o), 64'h0);
        check("sb_empty", 64'(sb_q.size()), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
